// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one big-endian unified memory port between
// instruction fetch (I) and load/store (D); sub-word stores run as read-modify-write.
module mem_arbiter #(
    parameter int  DATA_WIDTH = 32,
    parameter int  DEPTH      = 4096,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic                  d_we,
    input  logic [2:0]            d_funct3,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACC    = 2'd1;
    localparam logic [1:0] S_RMW_RD = 2'd2;
    localparam logic [1:0] S_RMW_WR = 2'd3;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [1:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [23:0]           merge_q, merge_d;
    logic [31:0]           i_rdata_q, i_rdata_d;
    logic [31:0]           d_rdata_q, d_rdata_d;
    logic                  i_rvalid_q, i_rvalid_d;
    logic                  d_rvalid_q, d_rvalid_d;

    logic                  grant_i;
    logic                  grant_d;
    logic [31:0]           load_word;

    // On contention the requester that did not win last time is served.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!reset && state_q == S_IDLE) begin
            if (i_valid && d_valid) begin
                if (last_grant_q == OWN_D) begin
                    grant_i = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else if (i_valid) begin
                grant_i = 1'b1;
            end else if (d_valid) begin
                grant_d = 1'b1;
            end
        end
    end

    assign i_ready = grant_i;
    assign d_ready = grant_d;

    // Byte k of the word lives at addr+k, so the addressed byte/half is in the top bits.
    always_comb begin
        case (funct3_q)
            3'b000:  load_word = {{24{mem_rdata[31]}}, mem_rdata[31:24]};
            3'b001:  load_word = {{16{mem_rdata[31]}}, mem_rdata[31:16]};
            3'b100:  load_word = {24'd0, mem_rdata[31:24]};
            3'b101:  load_word = {16'd0, mem_rdata[31:16]};
            default: load_word = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_rvalid_d   = 1'b0;
        d_rvalid_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_i) begin
                    addr_d       = i_addr;
                    owner_d      = OWN_I;
                    we_d         = 1'b0;
                    funct3_d     = 3'b010;
                    wdata_d      = 32'd0;
                    last_grant_d = OWN_I;
                    state_d      = S_ACC;
                end else if (grant_d) begin
                    addr_d       = d_addr;
                    owner_d      = OWN_D;
                    we_d         = d_we;
                    funct3_d     = d_funct3;
                    wdata_d      = d_wdata;
                    last_grant_d = OWN_D;
                    state_d      = (d_we && !d_funct3[1]) ? S_RMW_RD : S_ACC;
                end
            end
            S_ACC: begin
                if (we_q) begin
                    d_rvalid_d = 1'b1;
                end else if (owner_q == OWN_D) begin
                    d_rdata_d  = load_word;
                    d_rvalid_d = 1'b1;
                end else begin
                    i_rdata_d  = load_word;
                    i_rvalid_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            S_RMW_RD: begin
                merge_d = mem_rdata[23:0];
                state_d = S_RMW_WR;
            end
            S_RMW_WR: begin
                d_rvalid_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= OWN_D;
            owner_q      <= OWN_I;
            addr_q       <= '0;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            wdata_q      <= 32'd0;
            merge_q      <= 24'd0;
            i_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_rvalid_q   <= i_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
        end
    end

    // Write strobe is gated by reset so an interrupted store never commits.
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = 32'd0;
        if (!reset) begin
            if (state_q == S_ACC && we_q) begin
                mem_we    = 1'b1;
                mem_wdata = wdata_q;
            end else if (state_q == S_RMW_WR) begin
                mem_we    = 1'b1;
                mem_wdata = funct3_q[0] ? {wdata_q[15:0], merge_q[15:0]}
                                        : {wdata_q[7:0], merge_q[23:0]};
            end
        end
    end

    assign mem_addr = addr_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte-array memory model plus a
// byte-level reference memory that predicts load results, store effects and latency.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid, i_ready, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [31:0]   i_rdata;
    logic          d_valid, d_ready, d_we, d_rvalid;
    logic [2:0]    d_funct3;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata, d_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_we;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we), .d_funct3(d_funct3),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Memory environment: combinational big-endian read, synchronous word write.
    logic [7:0]    mem     [DEPTH];
    logic [7:0]    ref_mem [DEPTH];
    logic          bd_fill = 1'b0, bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [7:0]    bd_data = 8'd0, fill_seed = 8'd0;
    logic [AW-1:0] a1, a2, a3;

    assign a1 = mem_addr + 12'd1;
    assign a2 = mem_addr + 12'd2;
    assign a3 = mem_addr + 12'd3;
    assign mem_rdata = {mem[mem_addr], mem[a1], mem[a2], mem[a3]};

    function automatic logic [7:0] fill_byte(input int i, input logic [7:0] s);
        return 8'(i * 13) ^ 8'(i >> 4) ^ s;
    endfunction

    always @(posedge clk) begin
        if (bd_fill) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= fill_byte(k, fill_seed);
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata[31:24];
            mem[a1]       <= mem_wdata[23:16];
            mem[a2]       <= mem_wdata[15:8];
            mem[a3]       <= mem_wdata[7:0];
        end
    end

    int          n_assert = 0;
    int          n_fail   = 0;
    logic        last_owner_d;
    logic [31:0] exp_i_rdata, exp_d_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [AW-1:0] a);
        return {ref_mem[a], ref_mem[AW'(a + 1)], ref_mem[AW'(a + 2)], ref_mem[AW'(a + 3)]};
    endfunction

    function automatic logic [31:0] tb_word(input logic [AW-1:0] a);
        return {mem[a], mem[AW'(a + 1)], mem[AW'(a + 2)], mem[AW'(a + 3)]};
    endfunction

    // Loads take 1, 2 or 4 bytes starting at the address; signed variants extend the top bit.
    function automatic logic [31:0] expect_load(input logic [2:0] f3, input logic [31:0] w);
        int v;
        case (f3)
            3'b000: begin v = int'(w[31:24]); if (v >= 128) v -= 256; return 32'(v); end
            3'b001: begin v = int'(w[31:16]); if (v >= 32768) v -= 65536; return 32'(v); end
            3'b100: return 32'(int'(w[31:24]));
            3'b101: return 32'(int'(w[31:16]));
            default: return w;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [AW-1:0] a, input logic [31:0] wd);
        int size;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        for (int k = 0; k < size; k++) ref_mem[AW'(a + k)] = wd[8 * (size - 1 - k) +: 8];
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] b);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = b;
        ref_mem[a] = b;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic scramble_inputs();
        i_addr   = 12'($urandom);
        d_we     = 1'($urandom);
        d_funct3 = 3'($urandom);
        d_addr   = 12'($urandom);
        d_wdata  = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; i_valid = 1'b1; d_valid = 1'b1;
        #1;
        check("rst_i_ready", i_ready, 0);
        check("rst_d_ready", d_ready, 0);
        @(negedge clk);
        check("rst_i_ready_held", i_ready, 0);
        check("rst_outs", {i_rvalid, d_rvalid, mem_we}, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b0; i_valid = 1'b0; d_valid = 1'b0;
        last_owner_d = 1'b1;
        exp_i_rdata  = 32'd0;
        exp_d_rdata  = 32'd0;
    endtask

    // One transaction: issue, check grant, then check latency, write strobe and result.
    task automatic run_txn(input logic is_d, input logic contend, input logic we,
                           input logic [2:0] f3, input logic [AW-1:0] addr, input logic [31:0] wd);
        int          lat_exp, lat;
        logic        is_store, got, obs_rv;
        logic [31:0] exp_data, exp_word;
        is_store = is_d && we;
        exp_data = 32'd0;
        exp_word = 32'd0;
        if (is_store) begin
            ref_store(f3, addr, wd);
            exp_word = ref_word(addr);
            lat_exp  = f3[1] ? 2 : 3;
        end else begin
            exp_data = is_d ? expect_load(f3, ref_word(addr)) : ref_word(addr);
            lat_exp  = 2;
        end

        @(negedge clk);
        scramble_inputs();
        i_valid = !is_d || contend;
        d_valid = is_d || contend;
        if (!is_d) i_addr = addr;
        if (is_d) begin
            d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd;
        end else begin
            d_we = 1'b0;
        end
        #1;
        check("grant_i_ready", i_ready, !is_d);
        check("grant_d_ready", d_ready, is_d);
        @(posedge clk); #1;
        i_valid = 1'b0; d_valid = 1'b0;
        scramble_inputs();

        lat = 0; got = 1'b0;
        for (int c = 1; c <= 5 && !got; c++) begin
            @(negedge clk);
            check("mem_we", mem_we, is_store && (c == lat_exp - 1));
            if (is_store && c == lat_exp - 1) begin
                check("mem_wdata", mem_wdata, exp_word);
                check("mem_addr", 32'(mem_addr), 32'(addr));
            end
            check("other_rvalid", is_d ? i_rvalid : d_rvalid, 0);
            obs_rv = is_d ? d_rvalid : i_rvalid;
            if (obs_rv === 1'b1) begin got = 1'b1; lat = c; end
        end
        check("latency", lat, lat_exp);
        if (is_store) begin
            check("d_rdata_held", d_rdata, exp_d_rdata);
        end else if (is_d) begin
            exp_d_rdata = exp_data;
            check("d_rdata", d_rdata, exp_data);
        end else begin
            exp_i_rdata = exp_data;
            check("i_rdata", i_rdata, exp_data);
        end
        check(is_d ? "i_rdata_held" : "d_rdata_held_i", is_d ? i_rdata : d_rdata,
              is_d ? exp_i_rdata : exp_d_rdata);
        check("mem_contents", tb_word(addr), ref_word(addr));
        last_owner_d = is_d;
        @(negedge clk);
        check("rvalid_pulse", is_d ? d_rvalid : i_rvalid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          grants, prev;
        logic        exp_d, is_d, contend;
        logic [AW-1:0] a;

        reset = 1'b1; i_valid = 1'b0; d_valid = 1'b0;
        i_addr = '0; d_we = 1'b0; d_funct3 = 3'd0; d_addr = '0; d_wdata = 32'd0;
        fill_seed = 8'($urandom);
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = fill_byte(k, fill_seed);
        @(negedge clk); bd_fill = 1'b1;
        @(posedge clk); #1; bd_fill = 1'b0;
        poke(12'h000, 8'h13); poke(12'h001, 8'h05); poke(12'h002, 8'h00); poke(12'h003, 8'h00);
        poke(12'h010, 8'h80); poke(12'h011, 8'hFF); poke(12'h012, 8'h12); poke(12'h013, 8'h34);
        do_reset();

        // Directed: fetch, five load formats, then SB/SH/SW each followed by a word load.
        run_txn(1'b0, 1'b0, 1'b0, 3'b010, 12'h000, 32'd0);
        check("fetch_const", i_rdata, 32'h13050000);
        run_txn(1'b1, 1'b0, 1'b0, 3'b000, 12'h010, 32'd0);
        check("lb_const", d_rdata, 32'hFFFFFF80);
        run_txn(1'b1, 1'b0, 1'b0, 3'b100, 12'h010, 32'd0);
        run_txn(1'b1, 1'b0, 1'b0, 3'b001, 12'h010, 32'd0);
        run_txn(1'b1, 1'b0, 1'b0, 3'b101, 12'h010, 32'd0);
        run_txn(1'b1, 1'b0, 1'b0, 3'b010, 12'h010, 32'd0);
        run_txn(1'b1, 1'b0, 1'b1, 3'b000, 12'h010, 32'h000000AB);
        run_txn(1'b1, 1'b0, 1'b0, 3'b010, 12'h010, 32'd0);
        check("sb_const", d_rdata, 32'hABFF1234);
        run_txn(1'b1, 1'b0, 1'b1, 3'b001, 12'h010, 32'h0000BEEF);
        run_txn(1'b1, 1'b0, 1'b0, 3'b010, 12'h010, 32'd0);
        check("sh_const", d_rdata, 32'hBEEF1234);
        run_txn(1'b1, 1'b0, 1'b1, 3'b010, 12'h010, 32'hDEADBEEF);
        run_txn(1'b1, 1'b0, 1'b0, 3'b010, 12'h010, 32'd0);

        // Both requesters held valid: grants alternate starting with I after reset.
        do_reset();
        @(negedge clk);
        i_valid = 1'b1; d_valid = 1'b1; i_addr = 12'h000;
        d_we = 1'b0; d_funct3 = 3'b010; d_addr = 12'h010;
        exp_d = 1'b0; grants = 0; prev = 0;
        for (int c = 0; c < 20 && grants < 6; c++) begin
            #1;
            if (i_rvalid === 1'b1) check("alt_i_rdata", i_rdata, ref_word(12'h000));
            if (d_rvalid === 1'b1) check("alt_d_rdata", d_rdata, ref_word(12'h010));
            if (i_ready === 1'b1 || d_ready === 1'b1) begin
                check("alt_owner", d_ready, exp_d);
                check("alt_excl", i_ready & d_ready, 0);
                if (grants > 0) check("alt_gap", c - prev, 2);
                prev = c; grants++; exp_d = !exp_d;
            end
            @(negedge clk);
        end
        check("alt_count", grants, 6);
        i_valid = 1'b0; d_valid = 1'b0;
        repeat (3) @(negedge clk);
        last_owner_d = !exp_d;
        exp_i_rdata = ref_word(12'h000);
        exp_d_rdata = ref_word(12'h010);

        // Reset during the write phase of a byte store must leave memory untouched.
        @(negedge clk);
        d_valid = 1'b1; d_we = 1'b1; d_funct3 = 3'b000; d_addr = 12'h010; d_wdata = 32'h55;
        #1; check("rmwrst_d_ready", d_ready, 1);
        @(posedge clk); #1; d_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rmwrst_pre_we", mem_we, 1);
        reset = 1'b1;
        #1; check("rmwrst_we", mem_we, 0);
        @(negedge clk);
        check("rmwrst_outs", {i_ready, d_ready, i_rvalid, d_rvalid, mem_we}, 0);
        check("rmwrst_rdata", d_rdata | i_rdata, 0);
        check("rmwrst_mem_addr", 32'(mem_addr), 0);
        check("rmwrst_mem", tb_word(12'h010), ref_word(12'h010));
        reset = 1'b0;
        last_owner_d = 1'b1; exp_i_rdata = 32'd0; exp_d_rdata = 32'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rmwrst_no_rvalid", d_rvalid, 0);
        end

        // Randomized mix, including contention and wrap-around addresses.
        for (int t = 0; t < 80; t++) begin
            contend = ($urandom_range(0, 3) == 0);
            is_d    = contend ? !last_owner_d : 1'($urandom);
            a       = ($urandom_range(0, 7) == 0) ? 12'(12'hFFC + $urandom_range(0, 3))
                                                  : 12'($urandom);
            run_txn(is_d, contend, 1'($urandom), 3'($urandom), a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one byte-addressed, big-endian unified memory port between the instruction-fetch requester (I) and the load/store requester (D).
- The memory port has combinational read, synchronous 32-bit write, and byte k of the word at A = mem[A+k] (MSB first).
- Arbitration is round-robin. Load data is size-formatted and sign/zero-extended.
- The memory writes whole words only, so byte/half stores run as read-modify-write (RMW).

Parameters:
DATA_WIDTH, 32, data word width; only 32 is supported.
DEPTH, 4096, memory depth in bytes; ADDR_W = $clog2(DEPTH).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_valid  in  1  fetch request valid
i_ready  out  1  fetch request accepted this cycle
i_addr  in  ADDR_W  fetch byte address
i_rvalid  out  1  one-cycle pulse: i_rdata valid
i_rdata  out  32  fetched word
d_valid  in  1  data request valid
d_ready  out  1  data request accepted this cycle
d_we  in  1  1 = store, 0 = load
d_funct3  in  3  RV32I funct3 (size/sign)
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data; the sub-word is in the low bits
d_rvalid  out  1  one-cycle pulse: load data valid or store complete
d_rdata  out  32  formatted load data
mem_addr  out  ADDR_W  memory address
mem_wdata  out  32  memory write word
mem_we  out  1  memory write enable
mem_rdata  in  32  memory combinational read word

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, last_grant=D, and all of i_ready, d_ready, i_rvalid, d_rvalid, i_rdata, d_rdata, mem_addr, mem_wdata and mem_we are 0.
- States: IDLE, ACC, RMW_RD, RMW_WR.
- Grant in IDLE (combinational):
  - Only one of i_valid/d_valid high: that requester is granted.
  - Both high: the requester not equal to last_grant is granted.
  - The granted ready is high in the same cycle. Ready is never high outside IDLE or while reset is high.
- On acceptance (valid && ready):
  - Latch addr, owner, we, funct3 and wdata; update last_grant.
  - Next state is RMW_RD for a D store with funct3[1:0] in {00, 01}. Otherwise it is ACC.
  - Fetch is always a word load.
- mem_addr is driven by the latched address register.
- ACC:
  - Load: capture the formatted word into the owner's rdata register and pulse its rvalid in the next cycle.
  - Word store: mem_we=1, mem_wdata=wdata; pulse d_rvalid next cycle.
  - ACC always goes to IDLE. A new request can be accepted in the same cycle as the rvalid pulse.
- RMW_RD: register mem_rdata into merge; go to RMW_WR.
- RMW_WR:
  - mem_we=1.
  - SB: mem_wdata = {wdata[7:0], merge[23:0]}.
  - SH: mem_wdata = {wdata[15:0], merge[15:0]}.
  - Pulse d_rvalid next cycle; go to IDLE.
- Load formatting (w = mem_rdata):
  - 000 LB: sext(w[31:24]).
  - 001 LH: sext(w[31:16]).
  - 010 LW: w.
  - 100 LBU: zext(w[31:24]).
  - 101 LHU: zext(w[31:16]).
  - 011, 110, 111 are treated as LW.
  - Store funct3[1:0]=11 is treated as SW.
- Latency:
  - Load/fetch: accept at cycle N, rvalid at N+2.
  - SW: done at N+2.
  - SB/SH: done at N+3.
- d_rdata and i_rdata hold their value until the owner's next load completes. Stores do not change d_rdata.
- No alignment check is made. Addresses pass unchanged; addr+k wraps modulo DEPTH inside the memory.
- Reset mid-operation: state goes to IDLE and mem_we is forced 0 in any cycle where reset=1, so no partial RMW or store commits. Pending responses are dropped; rvalid is not pulsed.
- Requester inputs are ignored outside the accept cycle.

Test Plan:
- Fetch only: mem[0..3]=13,05,00,00, i_valid, i_addr=0 -> i_ready at cycle 0, i_rvalid at cycle 2, i_rdata=0x13050000; mem_we stays 0.
- Both valid continuously after reset -> grants alternate I, D, I, D; each grant waits until the previous transaction returns to IDLE.
- Loads: word at 0x10 = 0x80FF1234:
  - LB -> 0xFFFFFF80
  - LBU -> 0x00000080
  - LH -> 0xFFFF80FF
  - LHU -> 0x000080FF
  - LW -> 0x80FF1234
- SB wdata=0x000000AB to 0x10 over word 0x80FF1234 -> RMW_RD then RMW_WR; mem_wdata=0xABFF1234; d_rvalid at cycle 3. Follow-up LW reads 0xABFF1234.
- SH 0x0000BEEF -> word becomes 0xBEEF1234. SW 0xDEADBEEF -> mem_we only in the ACC cycle; d_rvalid at cycle 2.
- Reset asserted during RMW_WR -> mem_we=0 that cycle, memory unchanged, no d_rvalid, next state IDLE, all outputs 0.
